baser_257b_lane_scheduler: RTL and testbench

//  Round-robin scheduler that shares one BASER_257b_checker between N lanes of 257b transcoded traffic.

---
 rtl/baser_pkg.sv | 16 +
 rtl/baser_257b_lane_scheduler_rr_arbiter.sv | 46 ++++
 rtl/baser_257b_lane_scheduler.sv | 126 ++++++++++++
 tb/tb_baser_257b_lane_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/baser_pkg.sv
// rtl/baser_pkg.sv - shared 257b transcoding constants and lane id type
package baser_pkg;

    localparam int TC_WIDTH  = 257;
    localparam int MAX_LANES = 16;

    localparam logic [7:0] DATA_CHAR = 8'hAA;
    localparam logic [7:0] CTRL_CHAR = 8'h1E;
    localparam logic [7:0] OSET_CHAR = 8'h4B;

    // All-data block: header bit 0 set, payload of repeating data characters
    localparam logic [TC_WIDTH-1:0] IDLE_FILL = {{32{DATA_CHAR}}, 1'b1};

    typedef logic [$clog2(MAX_LANES)-1:0] lane_id_t;

endpackage

// File: rtl/baser_257b_lane_scheduler_rr_arbiter.sv
// rtl/baser_257b_lane_scheduler_rr_arbiter.sv - round-robin arbiter with internal last-winner pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any
);

    logic [$clog2(N)-1:0] ptr;

    // First pass looks strictly above the pointer, second pass wraps to the bottom
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (!any && req[k] && (k > int'(ptr))) begin
                    any      = 1'b1;
                    winner   = ($clog2(N))'(k);
                    grant[k] = 1'b1;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!any && req[k] && (k <= int'(ptr))) begin
                    any      = 1'b1;
                    winner   = ($clog2(N))'(k);
                    grant[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= ($clog2(N))'(N - 1);
        end else if (any) begin
            ptr <= winner;
        end
    end

endmodule

// File: rtl/baser_257b_lane_scheduler.sv
// rtl/baser_257b_lane_scheduler.sv - shares one 257b checker across lanes and attributes its invalid counts
module baser_257b_lane_scheduler
    import baser_pkg::*;
#(
    parameter int                      N_LANES     = 4,
    parameter int                      TC_WIDTH    = baser_pkg::TC_WIDTH,
    parameter int                      CNT_WIDTH   = 32,
    parameter int                      CHK_LATENCY = 1,
    parameter logic [TC_WIDTH-1:0]     IDLE_FILL   = baser_pkg::IDLE_FILL
) (
    input  logic                           clk,
    input  logic                           i_rst,
    input  logic [N_LANES-1:0]             i_lane_en,
    input  logic [N_LANES-1:0]             i_lane_valid,
    input  logic [N_LANES*TC_WIDTH-1:0]    i_lane_xcoded,
    output logic [N_LANES-1:0]             o_lane_ready,
    output logic [TC_WIDTH-1:0]            o_chk_xcoded,
    output logic                           o_chk_valid,
    output logic [$clog2(N_LANES)-1:0]     o_chk_lane,
    input  logic [31:0]                    i_chk_inv_count,
    output logic [N_LANES*CNT_WIDTH-1:0]   o_lane_blk_count,
    output logic [N_LANES*CNT_WIDTH-1:0]   o_lane_inv_count,
    output logic [CNT_WIDTH-1:0]           o_unattr_count
);

    localparam int                   LW      = $clog2(N_LANES);
    localparam int                   SW      = ((CNT_WIDTH > 32) ? CNT_WIDTH : 32) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [31:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    logic [N_LANES-1:0] req;
    logic [N_LANES-1:0] grant;
    logic [LW-1:0]      winner;
    logic               any;

    assign req          = i_lane_valid & i_lane_en;
    assign o_lane_ready = grant;

    rr_arbiter #(.N(N_LANES)) u_arb (
        .clk    (clk),
        .rst    (i_rst),
        .req    (req),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_chk_xcoded <= IDLE_FILL;
            o_chk_valid  <= 1'b0;
            o_chk_lane   <= '0;
        end else if (any) begin
            o_chk_xcoded <= i_lane_xcoded[int'(winner)*TC_WIDTH +: TC_WIDTH];
            o_chk_valid  <= 1'b1;
            o_chk_lane   <= winner;
        end else begin
            o_chk_xcoded <= IDLE_FILL;
            o_chk_valid  <= 1'b0;
        end
    end

    // Tag pipeline lines the issued lane up with the checker's delayed count update
    logic     [CHK_LATENCY-1:0] dly_valid;
    lane_id_t [CHK_LATENCY-1:0] dly_lane;
    logic     [31:0]            prev_inv;
    logic     [31:0]            delta;
    logic                       tail_valid;
    lane_id_t                   tail_lane;

    always_ff @(posedge clk) begin
        prev_inv <= i_chk_inv_count;
        if (i_rst) begin
            dly_valid <= '0;
            dly_lane  <= '0;
        end else begin
            dly_valid[0] <= o_chk_valid;
            dly_lane[0]  <= lane_id_t'(o_chk_lane);
            for (int i = 1; i < CHK_LATENCY; i++) begin
                dly_valid[i] <= dly_valid[i-1];
                dly_lane[i]  <= dly_lane[i-1];
            end
        end
    end

    assign delta      = i_chk_inv_count - prev_inv;
    assign tail_valid = dly_valid[CHK_LATENCY-1];
    assign tail_lane  = dly_lane[CHK_LATENCY-1];

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic [CNT_WIDTH-1:0] blk_cnt;
        logic [CNT_WIDTH-1:0] inv_cnt;

        always_ff @(posedge clk) begin
            if (i_rst) begin
                blk_cnt <= '0;
                inv_cnt <= '0;
            end else begin
                if (grant[k]) begin
                    blk_cnt <= sat_add(blk_cnt, 32'd1);
                end
                if ((delta != 32'd0) && tail_valid && (tail_lane == lane_id_t'(k))) begin
                    inv_cnt <= sat_add(inv_cnt, delta);
                end
            end
        end

        assign o_lane_blk_count[k*CNT_WIDTH +: CNT_WIDTH] = blk_cnt;
        assign o_lane_inv_count[k*CNT_WIDTH +: CNT_WIDTH] = inv_cnt;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_unattr_count <= '0;
        end else if ((delta != 32'd0) && !tail_valid) begin
            o_unattr_count <= sat_add(o_unattr_count, delta);
        end
    end

endmodule

// File: tb/tb_baser_257b_lane_scheduler.sv
// tb/tb_baser_257b_lane_scheduler.sv - scoreboard bench for the 257b lane scheduler
module tb_baser_257b_lane_scheduler;

    localparam int              NL   = 4;
    localparam int              TW   = 257;
    localparam int              CW   = 4;
    localparam logic [TW-1:0]   IDLE = {{32{8'hAA}}, 1'b1};

    typedef struct {
        int            lane;
        logic [TW-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [NL-1:0]      i_lane_en = '1;
    logic [NL-1:0]      i_lane_valid = '1;
    logic [NL*TW-1:0]   i_lane_xcoded = '0;
    logic [NL-1:0]      o_lane_ready;
    logic [TW-1:0]      o_chk_xcoded;
    logic               o_chk_valid;
    logic [1:0]         o_chk_lane;
    logic [31:0]        i_chk_inv_count;
    logic [NL*CW-1:0]   o_lane_blk_count;
    logic [NL*CW-1:0]   o_lane_inv_count;
    logic [CW-1:0]      o_unattr_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;
    exp_t exp_q[$];
    exp_t mon_x;

    // Stub checker: counts header-0/mask-1111 blocks, three cycles after they appear
    logic [1:0]  stub_pipe = 2'b00;
    logic [31:0] stub_cnt = 32'd0;
    logic        stub_force = 1'b0;
    logic [31:0] stub_force_val = 32'd0;

    assign i_chk_inv_count = stub_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        stub_pipe <= {stub_pipe[0], (!o_chk_xcoded[0] && (o_chk_xcoded[4:1] == 4'hF))};
        stub_cnt  <= stub_force ? stub_force_val : stub_cnt + 32'(stub_pipe[1]);
    end

    baser_257b_lane_scheduler #(
        .N_LANES     (NL),
        .TC_WIDTH    (TW),
        .CNT_WIDTH   (CW),
        .CHK_LATENCY (3),
        .IDLE_FILL   (IDLE)
    ) dut (
        .clk              (clk),
        .i_rst            (i_rst),
        .i_lane_en        (i_lane_en),
        .i_lane_valid     (i_lane_valid),
        .i_lane_xcoded    (i_lane_xcoded),
        .o_lane_ready     (o_lane_ready),
        .o_chk_xcoded     (o_chk_xcoded),
        .o_chk_valid      (o_chk_valid),
        .o_chk_lane       (o_chk_lane),
        .i_chk_inv_count  (i_chk_inv_count),
        .o_lane_blk_count (o_lane_blk_count),
        .o_lane_inv_count (o_lane_inv_count),
        .o_unattr_count   (o_unattr_count)
    );

    function automatic logic [TW-1:0] mk_blk(input int lane, input bit bad);
        logic [255:0] d;
        d = {32{8'(8'h10 + lane)}};
        return bad ? {d[255:4], 4'b1111, 1'b0} : {d, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (o_chk_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: lane %0d issued, expected nothing", o_chk_lane);
                end else begin
                    mon_x = exp_q.pop_front();
                    if (o_chk_lane !== 2'(mon_x.lane) || o_chk_xcoded !== mon_x.data) begin
                        n_fail++;
                        $display("FAIL issue: got lane %0d data %0h expected lane %0d data %0h",
                                 o_chk_lane, o_chk_xcoded[15:0], mon_x.lane, mon_x.data[15:0]);
                    end
                end
            end else begin
                n_checks++;
                if (o_chk_xcoded !== IDLE) begin
                    n_fail++;
                    $display("FAIL idle_fill: got %0h expected %0h", o_chk_xcoded[15:0], IDLE[15:0]);
                end
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0] e, input int bad, input int exp_lane);
        exp_t       x;
        logic [3:0] exp_rdy;
        @(negedge clk);
        i_lane_valid = v;
        i_lane_en    = e;
        for (int k = 0; k < NL; k++) i_lane_xcoded[k*TW +: TW] = mk_blk(k, bad == k);
        exp_rdy = 4'b0000;
        if (exp_lane >= 0) begin
            exp_rdy = 4'(1 << exp_lane);
            x.lane  = exp_lane;
            x.data  = mk_blk(exp_lane, bad == exp_lane);
            exp_q.push_back(x);
        end
        #1 chk("lane_ready", 64'(o_lane_ready), 64'(exp_rdy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 4'hF, -1, -1);
    endtask

    task automatic check_counts(input logic [15:0] blk, input logic [15:0] inv, input logic [3:0] un);
        chk("blk_count", 64'(o_lane_blk_count), 64'(blk));
        chk("inv_count", 64'(o_lane_inv_count), 64'(inv));
        chk("unattr_count", 64'(o_unattr_count), 64'(un));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_rst        = 1'b1;
            i_lane_valid = 4'hF;
            i_lane_en    = 4'hF;
            #1 chk("ready_in_reset", 64'(o_lane_ready), 64'd0);
        end
        @(negedge clk);
        i_rst        = 1'b0;
        i_lane_valid = 4'h0;
        chk("reset_chk_valid", 64'(o_chk_valid), 64'd0);
        chk("reset_chk_lane", 64'(o_chk_lane), 64'd0);
        check_counts(16'h0000, 16'h0000, 4'h0);
    endtask

    int sparse_exp[10] = '{1, 3, 1, 3, 1, 3, 1, 1, 1, 1};

    initial begin
        @(posedge clk);
        mon_on = 1'b1;

        do_reset(5);

        // Fairness: all four lanes requesting, strict 0,1,2,3 rotation
        for (int c = 0; c < 40; c++) step(4'hF, 4'hF, -1, c % 4);
        idle(6);
        check_counts(16'hAAAA, 16'h0000, 4'h0);

        // Attribution: one bad block from lane 2 in its second turn
        do_reset(2);
        for (int c = 0; c < 12; c++) step(4'hF, 4'hF, (c == 6) ? 2 : -1, c % 4);
        idle(6);
        check_counts(16'h3333, 16'h0100, 4'h0);

        // Reset with a lane-1 bad block in flight: its later increment lands as unattributed
        step(4'b0010, 4'hF, 1, 1);
        idle(1);
        do_reset(1);
        idle(6);
        check_counts(16'h0000, 16'h0000, 4'h1);

        // Sparse lanes 1 and 3, lane 3 disabled from the seventh cycle
        do_reset(2);
        for (int c = 0; c < 10; c++) step(4'b1010, (c < 6) ? 4'hF : 4'b0111, -1, sparse_exp[c]);
        idle(6);
        check_counts(16'h3070, 16'h0000, 4'h0);

        // Checker counter wraps from all-ones to zero on a lane-0 bad block
        stub_force_val = 32'hFFFF_FFFF;
        stub_force     = 1'b1;
        do_reset(3);
        stub_force     = 1'b0;
        step(4'b0001, 4'hF, 0, 0);
        idle(6);
        check_counts(16'h0001, 16'h0001, 4'h0);

        // Block counter saturation, then unattributed increments up to saturation
        do_reset(2);
        for (int c = 0; c < 20; c++) step(4'b0001, 4'hF, -1, 0);
        idle(5);
        check_counts(16'h000F, 16'h0000, 4'h0);
        stub_force_val = stub_cnt + 32'd5;
        stub_force     = 1'b1;
        idle(1);
        stub_force     = 1'b0;
        idle(4);
        check_counts(16'h000F, 16'h0000, 4'h5);
        stub_force_val = stub_cnt + 32'd20;
        stub_force     = 1'b1;
        idle(1);
        stub_force     = 1'b0;
        idle(4);
        check_counts(16'h000F, 16'h0000, 4'hF);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
